// File: rtl/net_tx_arbiter.sv
// net_tx_arbiter: round-robin arbiter that funnels NUM_REQ packet sources
// into one registered {dest, payload} flit toward the network interface.
// Optional build macro NET_TX_ARB_SELF_FILTER_EN: when defined, requests
// addressed to GPU_ID are accepted and counted in drop_count, not forwarded.
// Handshake: a request transfers on the rising edge where req_valid[i] and
// req_ready[i] are both high; a flit transfers on the edge where
// net_valid_out and net_ready_in are both high.
// The FSM has two states and busy mirrors it exactly (busy == S_SEND).
module net_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DEST_W  = 6,
    parameter int PAY_W   = 10,
    parameter int GPU_ID  = 19
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DEST_W-1:0] req_dest,
    input  logic [NUM_REQ*PAY_W-1:0]  req_payload,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [15:0]               net_data_out,
    output logic                      net_valid_out,
    input  logic                      net_ready_in,
    output logic [2:0]                grant_id,
    output logic                      busy,
    output logic [15:0]               tx_count,
    output logic [15:0]               drop_count
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [2:0]          last_grant;
    logic [2:0]          sel;
    logic [3:0]          cand;
    logic                found;
    logic                accept;
    logic                self_hit;
    logic                is_self;
    logic [DEST_W-1:0]   sel_dest;
    logic [PAY_W-1:0]    sel_pay;

    // Round-robin search starting one past the last granted requester, with wrap.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant} + 4'(k);
            if (cand >= 4'(NUM_REQ)) begin
                cand = cand - 4'(NUM_REQ);
            end
            if (!found && req_valid[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                sel   = cand[2:0];
            end
        end
    end

    // Pick the winning requester's destination and payload out of the packed buses.
    always_comb begin
        sel_dest = '0;
        sel_pay  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == 3'(i)) begin
                sel_dest = req_dest[i*DEST_W +: DEST_W];
                sel_pay  = req_payload[i*PAY_W +: PAY_W];
            end
        end
    end

    // Gated by ARESETn so nothing is offered while reset is held.
    assign accept  = ARESETn && (state_q == S_IDLE) && found;
    assign is_self = (sel_dest == DEST_W'(GPU_ID));

`ifdef NET_TX_ARB_SELF_FILTER_EN
    assign self_hit = is_self;
`else
    logic unused_self;
    assign unused_self = is_self;
    assign self_hit    = 1'b0;
`endif

    // One-hot ready toward the selected requester, only while idle.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[sel[IDX_W-1:0]] = 1'b1;
        end
    end

    // Next-state logic: a filtered request never enters S_SEND.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && !self_hit) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (net_ready_in) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Flit register, grant tracking and delivery counter.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            net_data_out  <= '0;
            net_valid_out <= 1'b0;
            last_grant    <= 3'(NUM_REQ - 1);
            grant_id      <= '0;
            tx_count      <= '0;
        end else begin
            if (accept) begin
                last_grant <= sel;
                grant_id   <= sel;
                if (!self_hit) begin
                    net_data_out  <= {sel_dest, sel_pay};
                    net_valid_out <= 1'b1;
                end
            end
            if ((state_q == S_SEND) && net_ready_in) begin
                net_valid_out <= 1'b0;
                tx_count      <= tx_count + 16'd1;
            end
        end
    end

`ifdef NET_TX_ARB_SELF_FILTER_EN
    // Count self-addressed requests that were swallowed instead of sent.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            drop_count <= '0;
        end else if (accept && self_hit) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`else
    assign drop_count = '0;
`endif

    assign busy = (state_q == S_SEND);

endmodule

// File: tb/tb_net_tx_arbiter.sv
// Directed bench for net_tx_arbiter: reset values, single transfer,
// round-robin rotation, back-pressure, reset during send, self-addressed
// requests and tx_count wrap.
module tb_net_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DEST_W  = 6;
    localparam int PAY_W   = 10;

    logic                      ACLK = 1'b0;
    logic                      ARESETn;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DEST_W-1:0] req_dest;
    logic [NUM_REQ*PAY_W-1:0]  req_payload;
    logic [NUM_REQ-1:0]        req_ready;
    logic [15:0]               net_data_out;
    logic                      net_valid_out;
    logic                      net_ready_in;
    logic [2:0]                grant_id;
    logic                      busy;
    logic [15:0]               tx_count;
    logic [15:0]               drop_count;

    int errors = 0;
    int checks = 0;

    net_tx_arbiter #(
        .NUM_REQ(NUM_REQ),
        .DEST_W (DEST_W),
        .PAY_W  (PAY_W),
        .GPU_ID (19)
    ) dut (
        .ACLK         (ACLK),
        .ARESETn      (ARESETn),
        .req_valid    (req_valid),
        .req_dest     (req_dest),
        .req_payload  (req_payload),
        .req_ready    (req_ready),
        .net_data_out (net_data_out),
        .net_valid_out(net_valid_out),
        .net_ready_in (net_ready_in),
        .grant_id     (grant_id),
        .busy         (busy),
        .tx_count     (tx_count),
        .drop_count   (drop_count)
    );

    // Clock
    always #5 ACLK = ~ACLK;

    // Driver: load one requester's destination and payload.
    task automatic set_req(input int i, input logic [DEST_W-1:0] d, input logic [PAY_W-1:0] p);
        req_dest[i*DEST_W +: DEST_W] = d;
        req_payload[i*PAY_W +: PAY_W] = p;
    endtask

    // Driver: clean reset, ends just after a falling edge with reset released.
    task automatic do_reset();
        ARESETn      = 1'b0;
        req_valid    = '0;
        req_dest     = '0;
        req_payload  = '0;
        net_ready_in = 1'b0;
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
    endtask

    task automatic test_reset();
        ARESETn      = 1'b0;
        req_valid    = 4'b1111;
        req_dest     = '0;
        req_payload  = '0;
        net_ready_in = 1'b1;
        repeat (2) @(negedge ACLK);
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        checks++; if (net_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", net_valid_out); end
        checks++; if (net_data_out !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", net_data_out); end
        checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (tx_count !== 16'd0) begin errors++; $display("FAIL reset_tx_count: got %0d expected 0", tx_count); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop_count: got %0d expected 0", drop_count); end
        req_valid = '0;
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
    endtask

    task automatic test_single();
        do_reset();
        set_req(0, 6'd20, 10'h123);
        req_valid    = 4'b0001;
        net_ready_in = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
        @(negedge ACLK);
        req_valid = '0;
        #1;
        checks++; if (net_valid_out !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", net_valid_out); end
        checks++; if (net_data_out !== 16'h5123) begin errors++; $display("FAIL single_data: got %h expected 5123", net_data_out); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
        checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL single_grant: got %0d expected 0", grant_id); end
        @(negedge ACLK);
        #1;
        checks++; if (net_valid_out !== 1'b0) begin errors++; $display("FAIL single_valid_one_cycle: got %b expected 0", net_valid_out); end
        checks++; if (tx_count !== 16'd1) begin errors++; $display("FAIL single_tx_count: got %0d expected 1", tx_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b expected 0", busy); end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_ready;
        logic [15:0] exp_data;
        int          exp_g;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            set_req(i, 6'(10 + i), 10'(256 + i));
        end
        req_valid    = 4'b1111;
        net_ready_in = 1'b1;
        for (int n = 0; n < 5; n++) begin
            exp_g     = n % NUM_REQ;
            exp_ready = 4'b0001 << exp_g;
            exp_data  = {6'(10 + exp_g), 10'(256 + exp_g)};
            #1;
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", n, req_ready, exp_ready); end
            @(negedge ACLK);
            if (n == 4) req_valid = '0;
            #1;
            checks++; if (grant_id !== 3'(exp_g)) begin errors++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", n, grant_id, exp_g); end
            checks++; if (net_valid_out !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d]: got %b expected 1", n, net_valid_out); end
            checks++; if (net_data_out !== exp_data) begin errors++; $display("FAIL rr_data[%0d]: got %h expected %h", n, net_data_out, exp_data); end
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rr_ready_in_send[%0d]: got %b expected 0000", n, req_ready); end
            @(negedge ACLK);
        end
        #1;
        checks++; if (tx_count !== 16'd5) begin errors++; $display("FAIL rr_tx_count: got %0d expected 5", tx_count); end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_req(2, 6'd2, 10'h2AA);
        req_valid    = 4'b0100;
        net_ready_in = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_ready_grant: got %b expected 0100", req_ready); end
        @(negedge ACLK);
        req_valid = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++; if (net_valid_out !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, net_valid_out); end
            checks++; if (net_data_out !== 16'h0AAA) begin errors++; $display("FAIL bp_data[%0d]: got %h expected 0aaa", c, net_data_out); end
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 0000", c, req_ready); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy[%0d]: got %b expected 1", c, busy); end
            if (c == 5) begin
                net_ready_in = 1'b1;
                req_valid    = '0;
            end
            @(negedge ACLK);
        end
        #1;
        checks++; if (net_valid_out !== 1'b0) begin errors++; $display("FAIL bp_delivered: got %b expected 0", net_valid_out); end
        checks++; if (tx_count !== 16'd1) begin errors++; $display("FAIL bp_tx_count: got %0d expected 1", tx_count); end
        checks++; if (grant_id !== 3'd2) begin errors++; $display("FAIL bp_grant: got %0d expected 2", grant_id); end
    endtask

    task automatic test_reset_mid_send();
        @(negedge ACLK);
        set_req(1, 6'd33, 10'h055);
        req_valid    = 4'b0010;
        net_ready_in = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rst_send_ready: got %b expected 0010", req_ready); end
        @(negedge ACLK);
        req_valid = '0;
        #1;
        checks++; if (net_valid_out !== 1'b1) begin errors++; $display("FAIL rst_send_valid: got %b expected 1", net_valid_out); end
        #1;
        ARESETn   = 1'b0;
        req_valid = 4'b1111;
        #1;
        checks++; if (net_valid_out !== 1'b0) begin errors++; $display("FAIL rst_send_drop: got %b expected 0", net_valid_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_send_busy: got %b expected 0", busy); end
        checks++; if (tx_count !== 16'd0) begin errors++; $display("FAIL rst_send_tx_count: got %0d expected 0", tx_count); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_send_ready_held: got %b expected 0000", req_ready); end
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_send_priority: got %b expected 0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_self_addr();
        do_reset();
        set_req(0, 6'd19, 10'h0AB);
        req_valid    = 4'b0001;
        net_ready_in = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL self_ready: got %b expected 0001", req_ready); end
        @(negedge ACLK);
        req_valid = '0;
        #1;
`ifdef NET_TX_ARB_SELF_FILTER_EN
        checks++; if (net_valid_out !== 1'b0) begin errors++; $display("FAIL self_valid: got %b expected 0", net_valid_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL self_busy: got %b expected 0", busy); end
        checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL self_drop: got %0d expected 1", drop_count); end
        checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL self_grant: got %0d expected 0", grant_id); end
        @(negedge ACLK);
        #1;
        checks++; if (tx_count !== 16'd0) begin errors++; $display("FAIL self_tx_count: got %0d expected 0", tx_count); end
`else
        checks++; if (net_valid_out !== 1'b1) begin errors++; $display("FAIL self_valid: got %b expected 1", net_valid_out); end
        checks++; if (net_data_out !== 16'h4CAB) begin errors++; $display("FAIL self_data: got %h expected 4cab", net_data_out); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL self_drop: got %0d expected 0", drop_count); end
        @(negedge ACLK);
        #1;
        checks++; if (tx_count !== 16'd1) begin errors++; $display("FAIL self_tx_count: got %0d expected 1", tx_count); end
`endif
    endtask

    task automatic test_wrap();
        do_reset();
        force dut.tx_count = 16'hFFFE;
        #1;
        release dut.tx_count;
        set_req(0, 6'd5, 10'h00F);
        req_valid    = 4'b0001;
        net_ready_in = 1'b1;
        repeat (2) @(negedge ACLK);
        #1;
        checks++; if (tx_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff: got %h expected ffff", tx_count); end
        repeat (2) @(negedge ACLK);
        req_valid = '0;
        #1;
        checks++; if (tx_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h expected 0000", tx_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid_send();
        test_self_addr();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
